// File: rtl/fan_in_fifo_ctrl_pkg.sv
// fan_in_fifo_ctrl_pkg: link token types and fan-in controller state encoding
//   FTk_t         forward token {v, a, r, c, d}
//   BTk_t         back-prop token {n, t, v, c}
//   fanin_state_t controller state {IDLE, XFER}
package fan_in_fifo_ctrl_pkg;

    localparam int WIDTH_DATA = 32;

    typedef struct packed {
        logic                  v;
        logic                  a;
        logic                  r;
        logic                  c;
        logic [WIDTH_DATA-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;

    typedef enum logic {IDLE, XFER} fanin_state_t;

endpackage

// File: rtl/fan_in_fifo_ctrl_if.sv
// fan_in_fifo_ctrl_if: bundle of the fan-in controller's link-level token signals
//   I_FTk0/I_FTk1  forward tokens from upstream ports 0/1
//   O_BTk0/O_BTk1  back-prop tokens to upstream ports 0/1
//   O_FTk/I_BTk    merged forward / back-prop tokens on the downstream link
//   O_Grt/O_Busy   one-hot owner and activity status
//   slave = controller side, master = environment side
interface fan_in_fifo_ctrl_if;
    import fan_in_fifo_ctrl_pkg::*;

    FTk_t       I_FTk0;
    BTk_t       O_BTk0;
    FTk_t       I_FTk1;
    BTk_t       O_BTk1;
    FTk_t       O_FTk;
    BTk_t       I_BTk;
    logic [1:0] O_Grt;
    logic       O_Busy;

    modport slave  (input  I_FTk0, I_FTk1, I_BTk,
                    output O_BTk0, O_BTk1, O_FTk, O_Grt, O_Busy);
    modport master (output I_FTk0, I_FTk1, I_BTk,
                    input  O_BTk0, O_BTk1, O_FTk, O_Grt, O_Busy);

endinterface

// File: rtl/fan_in_fifo_ctrl_rr_arb.sv
// fan_in_fifo_ctrl_rr_arb: 2-way round-robin arbiter for the fan-in controller
//   clock, reset  clock, async active-low reset
//   req[1:0]      per-port requests
//   en            arbitration enabled this cycle
//   gnt[1:0]      one-hot grant (0 when disabled or no request)
//   last          port granted most recently (1 after reset so port 0 wins first)
module fan_in_fifo_ctrl_rr_arb (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       last
);

    logic last_q, last_d;

    always_comb begin
        gnt = 2'b00;
        if (en)
            gnt = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;
        last_d = (gnt != 2'b00) ? gnt[1] : last_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            last_q <= 1'b1;
        else
            last_q <= last_d;
    end

    assign last = last_q;

endmodule

// File: rtl/fan_in_fifo_ctrl.sv
// fan_in_fifo_ctrl: merges two upstream token streams into one, per message, through a token FIFO
//   clock, reset  clock, async active-low reset
//   bus.I_FTk0/1  upstream forward tokens;     bus.O_BTk0/1 back-prop to upstream
//   bus.O_FTk     merged forward tokens (FIFO head); bus.I_BTk back-prop from downstream
//   bus.O_Grt     one-hot owner, 0 when idle;  bus.O_Busy  not idle or FIFO non-empty
module fan_in_fifo_ctrl
    import fan_in_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH_FIFO = 8,
    parameter int THRESHOLD  = DEPTH_FIFO - 2
) (
    input  logic               clock,
    input  logic               reset,
    fan_in_fifo_ctrl_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_FIFO);
    localparam int CW = AW + 1;

    fan_in_fifo_ctrl_pkg::fanin_state_t state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    FTk_t          mem_q [DEPTH_FIFO];

    logic [1:0] v, req, gnt, n, acc;
    logic       last, full_th, push, pop, route;
    FTk_t       own_tok;
    BTk_t       b0, b1;
    logic       unused_bv;

    assign unused_bv = bus.I_BTk.v;
    assign v   = {bus.I_FTk1.v, bus.I_FTk0.v};
    assign req = v & {bus.I_FTk1.a, bus.I_FTk0.a};

    fan_in_fifo_ctrl_rr_arb u_arb (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .en    (state_q == IDLE),
        .gnt   (gnt),
        .last  (last)
    );

    always_comb begin
        full_th = cnt_q >= CW'(THRESHOLD);
        // Everyone with a valid token is held off except the owner during a transfer,
        // whose stall depends only on FIFO headroom.
        n = v;
        if (state_q == XFER)
            n = (v & ~owner_q) | (owner_q & {2{full_th}});
        acc     = v & ~n;
        push    = |acc;
        own_tok = owner_q[1] ? bus.I_FTk1 : bus.I_FTk0;
        pop     = (cnt_q != '0) && !bus.I_BTk.n;
        state_d = state_q;
        owner_d = owner_q;
        if (state_q == IDLE && gnt != 2'b00) begin
            state_d = XFER;
            owner_d = gnt;
        end
        if (state_q == XFER && push && own_tok.r) begin
            state_d = IDLE;
            owner_d = 2'b00;
        end
        wr_d  = wr_q + AW'(push);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        // Terminate/credit go back to the owner, or to the last owner while idle.
        route = (state_q == XFER) ? owner_q[1] : last;
        b0    = '0;
        b1    = '0;
        b0.n  = reset & n[0];
        b1.n  = reset & n[1];
        b0.t  = reset & !route & bus.I_BTk.t;
        b0.c  = reset & !route & bus.I_BTk.c;
        b1.t  = reset & route & bus.I_BTk.t;
        b1.c  = reset & route & bus.I_BTk.c;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 2'b00;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem_q[wr_q] <= own_tok;
    end

    assign bus.O_BTk0 = b0;
    assign bus.O_BTk1 = b1;
    assign bus.O_FTk  = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign bus.O_Grt  = owner_q;
    assign bus.O_Busy = (state_q != IDLE) || (cnt_q != '0);

endmodule

// File: tb/tb_fan_in_fifo_ctrl.sv
// tb_fan_in_fifo_ctrl: directed bench with a queue-based reference model checked every cycle
module tb_fan_in_fifo_ctrl;
    import fan_in_fifo_ctrl_pkg::*;

    localparam int DEPTH = 8;
    localparam int TH    = DEPTH - 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    fan_in_fifo_ctrl_if bus();

    fan_in_fifo_ctrl #(.DEPTH_FIFO(DEPTH), .THRESHOLD(TH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          tests = 0;
    int          fails = 0;
    int          m_own = -1;
    int          m_last = 1;
    FTk_t        mq[$];
    logic [1:0]  m_acc;
    logic [31:0] obs[$];
    logic [31:0] eseq[$];
    FTk_t        msg0[$];
    FTk_t        msg1[$];
    int          i0 = 0;
    int          i1 = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic FTk_t tok(input logic a, input logic r, input logic [31:0] d);
        FTk_t t;
        t   = '0;
        t.v = 1'b1;
        t.a = a;
        t.r = r;
        t.d = d;
        return t;
    endfunction

    // Reference: owner index (-1 idle), last owner, FIFO as a queue of tokens.
    task automatic model_step();
        FTk_t       t0, t1, tk, ef;
        BTk_t       e0, e1;
        logic [1:0] en, rq, eg;
        int         own, rt;
        t0    = bus.I_FTk0;
        t1    = bus.I_FTk1;
        m_acc = 2'b00;
        tk    = '0;
        if (!reset) begin
            m_own  = -1;
            m_last = 1;
            mq.delete();
            chk("rst_btk0", 64'(bus.O_BTk0), 64'(0));
            chk("rst_btk1", 64'(bus.O_BTk1), 64'(0));
            chk("rst_ftk",  64'(bus.O_FTk),  64'(0));
            chk("rst_grt",  64'(bus.O_Grt),  64'(0));
            chk("rst_busy", 64'(bus.O_Busy), 64'(0));
            return;
        end
        own   = m_own;
        en[0] = (own == 0) ? (mq.size() >= TH) : t0.v;
        en[1] = (own == 1) ? (mq.size() >= TH) : t1.v;
        rt    = (own >= 0) ? own : m_last;
        e0    = '0;
        e1    = '0;
        e0.n  = en[0];
        e1.n  = en[1];
        if (rt == 0) begin
            e0.t = bus.I_BTk.t;
            e0.c = bus.I_BTk.c;
        end else begin
            e1.t = bus.I_BTk.t;
            e1.c = bus.I_BTk.c;
        end
        ef = (mq.size() > 0) ? mq[0] : '0;
        eg = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
        chk("btk0", 64'(bus.O_BTk0), 64'(e0));
        chk("btk1", 64'(bus.O_BTk1), 64'(e1));
        chk("ftk",  64'(bus.O_FTk),  64'(ef));
        chk("grt",  64'(bus.O_Grt),  64'(eg));
        chk("busy", 64'(bus.O_Busy), 64'((own >= 0) || (mq.size() > 0)));
        if (bus.O_FTk.v && !bus.I_BTk.n)
            obs.push_back(bus.O_FTk.d);
        if (own >= 0) begin
            tk         = (own == 1) ? t1 : t0;
            m_acc[own] = tk.v && !en[own];
        end
        if (m_acc != 2'b00)
            chk("fifo_room", 64'(mq.size() < DEPTH), 64'(1));
        if (mq.size() > 0 && !bus.I_BTk.n)
            void'(mq.pop_front());
        if (m_acc != 2'b00) begin
            mq.push_back(tk);
            if (tk.r)
                m_own = -1;
        end
        if (own < 0) begin
            rq = {t1.v & t1.a, t0.v & t0.a};
            if (rq == 2'b11)
                m_own = 1 - m_last;
            else if (rq[0])
                m_own = 0;
            else if (rq[1])
                m_own = 1;
            if (m_own >= 0)
                m_last = m_own;
        end
    endtask

    task automatic cyc();
        @(negedge clock);
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic mk(input int p, input int n, input logic [31:0] base);
        if (p == 0) begin
            msg0.delete();
            i0 = 0;
        end else begin
            msg1.delete();
            i1 = 0;
        end
        for (int i = 0; i < n; i++) begin
            if (p == 0)
                msg0.push_back(tok(i == 0, i == n - 1, base + 32'(i)));
            else
                msg1.push_back(tok(i == 0, i == n - 1, base + 32'(i)));
        end
    endtask

    task automatic stepc();
        bus.I_FTk0 = (i0 < msg0.size()) ? msg0[i0] : '0;
        bus.I_FTk1 = (i1 < msg1.size()) ? msg1[i1] : '0;
        cyc();
        if (m_acc[0]) i0++;
        if (m_acc[1]) i1++;
    endtask

    task automatic run(input int budget);
        int b;
        b = budget;
        while ((i0 < msg0.size() || i1 < msg1.size()) && b > 0) begin
            stepc();
            b--;
        end
        chk("stream_done", 64'(i0 >= msg0.size() && i1 >= msg1.size()), 64'(1));
    endtask

    task automatic drain();
        int b;
        b = 40;
        bus.I_FTk0 = '0;
        bus.I_FTk1 = '0;
        msg0.delete();
        msg1.delete();
        i0 = 0;
        i1 = 0;
        while ((mq.size() > 0 || m_own >= 0) && b > 0) begin
            cyc();
            b--;
        end
        cyc();
        chk("drained", 64'(bus.O_Busy), 64'(0));
    endtask

    task automatic chk_seq(input string nm);
        chk({nm, "_len"}, 64'(obs.size()), 64'(eseq.size()));
        for (int i = 0; i < eseq.size() && i < obs.size(); i++)
            chk({nm, "_d"}, 64'(obs[i]), 64'(eseq[i]));
    endtask

    task automatic reset_dut();
        reset      = 1'b0;
        bus.I_FTk0 = '0;
        bus.I_FTk1 = '0;
        bus.I_BTk  = '0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        bus.I_FTk0 = '0;
        bus.I_FTk1 = '0;
        bus.I_BTk  = '0;
        reset_dut();
        chk("init_grt",  64'(bus.O_Grt),  64'(0));
        chk("init_busy", 64'(bus.O_Busy), 64'(0));
        chk("init_ftk",  64'(bus.O_FTk),  64'(0));

        // Three-token message on port 0, no stall
        obs.delete();
        bus.I_FTk0 = tok(1'b1, 1'b0, 32'h10);
        cyc();
        chk("t1_grt", 64'(bus.O_Grt), 64'(2'b01));
        cyc();
        chk("t1_d10", 64'(bus.O_FTk.d), 64'h10);
        chk("t1_v10", 64'(bus.O_FTk.v), 64'(1));
        bus.I_FTk0 = tok(1'b0, 1'b0, 32'h11);
        cyc();
        chk("t1_d11", 64'(bus.O_FTk.d), 64'h11);
        bus.I_FTk0 = tok(1'b0, 1'b1, 32'h12);
        cyc();
        chk("t1_d12", 64'(bus.O_FTk.d), 64'h12);
        chk("t1_grt0", 64'(bus.O_Grt), 64'(0));
        bus.I_FTk0 = '0;
        cyc();
        chk("t1_busy0", 64'(bus.O_Busy), 64'(0));
        chk("t1_v0", 64'(bus.O_FTk.v), 64'(0));

        // Simultaneous requests after reset: port 0 first, no interleaving
        reset_dut();
        obs.delete();
        mk(0, 2, 32'h20);
        mk(1, 3, 32'h30);
        stepc();
        chk("t2_grt0", 64'(bus.O_Grt), 64'(2'b01));
        chk("t2_nack1", 64'(bus.O_BTk1.n), 64'(1));
        run(40);
        drain();
        eseq.delete();
        eseq.push_back(32'h20);
        eseq.push_back(32'h21);
        eseq.push_back(32'h30);
        eseq.push_back(32'h31);
        eseq.push_back(32'h32);
        chk_seq("t2_seq");

        // Downstream stall while port 1 streams 10 tokens
        obs.delete();
        mk(1, 10, 32'h40);
        bus.I_BTk.n = 1'b1;
        repeat (12) stepc();
        chk("t3_nack", 64'(bus.O_BTk1.n), 64'(1));
        chk("t3_head", 64'(bus.O_FTk.d), 64'h40);
        bus.I_BTk.n = 1'b0;
        run(60);
        drain();
        eseq.delete();
        for (int i = 0; i < 10; i++)
            eseq.push_back(32'h40 + 32'(i));
        chk_seq("t3_seq");

        // Single-token message on port 1, then an immediate new request
        obs.delete();
        bus.I_FTk1 = tok(1'b1, 1'b1, 32'hAB);
        cyc();
        chk("t4_grt", 64'(bus.O_Grt), 64'(2'b10));
        cyc();
        chk("t4_dab", 64'(bus.O_FTk.d), 64'hAB);
        chk("t4_idle", 64'(bus.O_Grt), 64'(0));
        bus.I_FTk1 = tok(1'b1, 1'b1, 32'hAC);
        cyc();
        chk("t4_regrt", 64'(bus.O_Grt), 64'(2'b10));
        cyc();
        drain();
        eseq.delete();
        eseq.push_back(32'hAB);
        eseq.push_back(32'hAC);
        chk_seq("t4_seq");

        // Terminate routed to the owner during port 0's transfer
        bus.I_FTk0 = tok(1'b1, 1'b0, 32'h50);
        cyc();
        bus.I_BTk.t = 1'b1;
        #1;
        chk("t5_t0", 64'(bus.O_BTk0.t), 64'(1));
        chk("t5_t1", 64'(bus.O_BTk1.t), 64'(0));
        cyc();
        bus.I_BTk.t = 1'b0;
        bus.I_FTk0 = tok(1'b0, 1'b1, 32'h51);
        cyc();
        drain();

        // Reset mid-transfer with three tokens buffered
        mk(0, 5, 32'h80);
        bus.I_BTk.n = 1'b1;
        for (int b = 0; b < 20 && i0 < 3; b++)
            stepc();
        chk("t6_buffered", 64'(i0), 64'(3));
        reset = 1'b0;
        #1;
        chk("t6_ftk",  64'(bus.O_FTk),  64'(0));
        chk("t6_grt",  64'(bus.O_Grt),  64'(0));
        chk("t6_busy", 64'(bus.O_Busy), 64'(0));
        chk("t6_btk0", 64'(bus.O_BTk0), 64'(0));
        cyc();
        msg0.delete();
        i0 = 0;
        bus.I_FTk0 = '0;
        bus.I_BTk  = '0;
        reset = 1'b1;
        cyc();
        chk("t6_v0", 64'(bus.O_FTk.v), 64'(0));
        obs.delete();
        mk(0, 1, 32'h60);
        mk(1, 1, 32'h70);
        stepc();
        chk("t6_grt0", 64'(bus.O_Grt), 64'(2'b01));
        run(20);
        drain();
        eseq.delete();
        eseq.push_back(32'h60);
        eseq.push_back(32'h70);
        chk_seq("t6_seq");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
